// File: rtl/dw_window_gen.sv
// -----------------------------------------------------------------------------
// dw_window_gen
//   Builds 3x3 pixel windows for a depthwise convolution from a stream of
//   vertical 3-pixel columns. Each channel is handled in parallel. Windows are
//   emitted at stride 1 or stride 2 and never straddle a row boundary. The last
//   window of a frame is flagged with eof.
//
// Ports
//   clk          rising-edge clock
//   rstn         asynchronous active-low reset
//   col_in       one column per channel. Row r=0 is the newest (bottom) row and
//                r=2 is the oldest (top) row. The slice is
//                [(r*CHANNEL_NUM+ch)*DATA_WIDTH +: DATA_WIDTH]
//   valid_in     col_in carries a column this cycle
//   frame_start  single-cycle pulse that starts a frame. It is accepted only
//                when both dimensions are >= 3
//   img_width    columns per row, sampled on an accepted frame_start
//   img_height   rows per frame, sampled on an accepted frame_start
//   stride2      1 selects stride 2, 0 selects stride 1; sampled with the
//                dimensions
//   win_out      registered 3x3 window. Tap k=3*tr+tc (tr=0 top, tc=0 left)
//                of channel ch is at [(k*CHANNEL_NUM+ch)*DATA_WIDTH +: DATA_WIDTH]
//   valid_out    win_out was updated with a new window this cycle
//   eof          frame finished. It coincides with the final window, if there
//                is one
//   busy         a frame is in progress (RUN or FLUSH)
// -----------------------------------------------------------------------------
module dw_window_gen #(
   parameter int DATA_WIDTH  = 8,
   parameter int CHANNEL_NUM = 18,
   parameter int MAX_DIM     = 320,
   parameter int DIM_W       = $clog2(MAX_DIM + 1)
) (
   input  logic                                clk,
   input  logic                                rstn,
   input  logic [CHANNEL_NUM*3*DATA_WIDTH-1:0] col_in,
   input  logic                                valid_in,
   input  logic                                frame_start,
   input  logic [DIM_W-1:0]                    img_width,
   input  logic [DIM_W-1:0]                    img_height,
   input  logic                                stride2,
   output logic [CHANNEL_NUM*9*DATA_WIDTH-1:0] win_out,
   output logic                                valid_out,
   output logic                                eof,
   output logic                                busy
);

   localparam int COL_W = CHANNEL_NUM * 3 * DATA_WIDTH;
   localparam int WIN_W = CHANNEL_NUM * 9 * DATA_WIDTH;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [DIM_W-1:0] width_q;
   logic [DIM_W-1:0] height_q;
   logic             stride2_q;
   logic [DIM_W-1:0] col_cnt;
   logic [DIM_W-1:0] row_cnt;

   // Column history. s0 holds the previous column and s1 the one before it.
   // After the shift, the oldest column (s2) is exactly what s1 holds now, so
   // a third register would never be read.
   logic [COL_W-1:0] s0;
   logic [COL_W-1:0] s1;

   logic [WIN_W-1:0] win_nxt;
   logic             start_ok;
   logic             accept;
   logic             last_col;
   logic             last_row;
   logic             emit;

   // A frame_start with a degenerate size is ignored entirely.
   assign start_ok = frame_start && (img_width >= DIM_W'(3)) && (img_height >= DIM_W'(3));

   // An accepted frame_start takes the column for itself: it becomes column 0
   // of the new frame instead of being counted in the old one.
   assign accept   = (state == RUN) && valid_in && !start_ok;
   assign last_col = (col_cnt == width_q - DIM_W'(1));
   assign last_row = (row_cnt == height_q - DIM_W'(1));

   // The col_cnt >= 2 gate also keeps the previous row's tail out of a window.
   assign emit     = accept && (col_cnt >= DIM_W'(2)) && (row_cnt >= DIM_W'(2)) &&
                     (!stride2_q || (!col_cnt[0] && !row_cnt[0]));

   // ---------------------------------------------------------------- state reg
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge value of the others, independent of statement order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   // --------------------------------------------------------------- next state
   // NOTE: default assignment first, so no path through the block leaves
   // state_nxt unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      if (start_ok) begin
         state_nxt = RUN;
      end else begin
         case (state)
            RUN:     if (accept && last_col && last_row) state_nxt = FLUSH;
            FLUSH:   state_nxt = IDLE;
            default: state_nxt = state;
         endcase
      end
   end

   // ------------------------------------------------------------------ outputs
   always_comb begin
      busy = (state != IDLE);
      eof  = (state == FLUSH);
   end

   // ---------------------------------------------------------- window assembly
   // Left column = s1, middle column = s0, right column = col_in.
   // The top tap row comes from the oldest input row (r=2).
   always_comb begin
      win_nxt = '0;
      for (int ch = 0; ch < CHANNEL_NUM; ch++) begin
         for (int tr = 0; tr < 3; tr++) begin
            win_nxt[((3*tr+0)*CHANNEL_NUM+ch)*DATA_WIDTH +: DATA_WIDTH] =
               s1[((2-tr)*CHANNEL_NUM+ch)*DATA_WIDTH +: DATA_WIDTH];
            win_nxt[((3*tr+1)*CHANNEL_NUM+ch)*DATA_WIDTH +: DATA_WIDTH] =
               s0[((2-tr)*CHANNEL_NUM+ch)*DATA_WIDTH +: DATA_WIDTH];
            win_nxt[((3*tr+2)*CHANNEL_NUM+ch)*DATA_WIDTH +: DATA_WIDTH] =
               col_in[((2-tr)*CHANNEL_NUM+ch)*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // ----------------------------------------------------------------- datapath
   // NOTE: the column history is a handful of flops, not a RAM, so it can take
   // the asynchronous reset. That guarantees a stale window is never emitted
   // after reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         width_q   <= '0;
         height_q  <= '0;
         stride2_q <= 1'b0;
         col_cnt   <= '0;
         row_cnt   <= '0;
         s0        <= '0;
         s1        <= '0;
         win_out   <= '0;
         valid_out <= 1'b0;
      end else if (start_ok) begin
         width_q   <= img_width;
         height_q  <= img_height;
         stride2_q <= stride2;
         row_cnt   <= '0;
         s1        <= '0;
         valid_out <= 1'b0;
         if (valid_in) begin
            col_cnt <= DIM_W'(1);
            s0      <= col_in;
         end else begin
            col_cnt <= '0;
            s0      <= '0;
         end
      end else begin
         valid_out <= emit;
         if (accept) begin
            s1 <= s0;
            s0 <= col_in;
            if (last_col) begin
               col_cnt <= '0;
               row_cnt <= row_cnt + DIM_W'(1);
            end else begin
               col_cnt <= col_cnt + DIM_W'(1);
            end
         end
         if (emit) win_out <= win_nxt;
      end
   end

endmodule

// File: tb/tb_dw_window_gen.sv
// -----------------------------------------------------------------------------
// tb_dw_window_gen
//   Drives frames of column data into dw_window_gen. Each pixel is defined by
//   its (channel, row, col) position in an image array. The expected outputs
//   after every clock edge are derived from the image coordinates of the
//   column just driven.
// -----------------------------------------------------------------------------
module tb_dw_window_gen;

   localparam int DW   = 8;
   localparam int CH   = 2;
   localparam int MAXD = 16;
   localparam int DIMW = $clog2(MAXD + 1);
   localparam int COLW = CH * 3 * DW;
   localparam int WINW = CH * 9 * DW;

   // Channel-0 taps of the first window of a 4x4 frame whose pixel = 16*row+col.
   localparam logic [71:0] TAP_REF = 72'h00_01_02_10_11_12_20_21_22;

   logic            clk;
   logic            rstn;
   logic [COLW-1:0] col_in;
   logic            valid_in;
   logic            frame_start;
   logic [DIMW-1:0] img_width;
   logic [DIMW-1:0] img_height;
   logic            stride2;
   logic [WINW-1:0] win_out;
   logic            valid_out;
   logic            eof;
   logic            busy;

   dw_window_gen #(
      .DATA_WIDTH (DW),
      .CHANNEL_NUM(CH),
      .MAX_DIM    (MAXD)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .col_in     (col_in),
      .valid_in   (valid_in),
      .frame_start(frame_start),
      .img_width  (img_width),
      .img_height (img_height),
      .stride2    (stride2),
      .win_out    (win_out),
      .valid_out  (valid_out),
      .eof        (eof),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int              n_checks;
   int              n_errors;
   int              n_win;
   logic            exp_vld;
   logic            exp_eof;
   logic            exp_busy;
   logic [WINW-1:0] exp_win;
   logic [WINW-1:0] first_win;
   logic [DW-1:0]   img [CH][MAXD][MAXD];

   task automatic check(input string tag, input logic [WINW-1:0] got, input logic [WINW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Rows above the image are never part of a window; they get filler data.
   function automatic logic [DW-1:0] pix(input int ch, input int row, input int col);
      if (row < 0) return 8'hEE;
      return img[ch][row][col];
   endfunction

   function automatic logic [COLW-1:0] make_col(input int row, input int col);
      logic [COLW-1:0] c;
      c = '0;
      for (int r = 0; r < 3; r++)
         for (int ch = 0; ch < CH; ch++)
            c[(r*CH+ch)*DW +: DW] = pix(ch, row - r, col);
      return c;
   endfunction

   // Window whose bottom-right pixel is at (row, col).
   function automatic logic [WINW-1:0] make_win(input int row, input int col);
      logic [WINW-1:0] w;
      w = '0;
      for (int tr = 0; tr < 3; tr++)
         for (int tc = 0; tc < 3; tc++)
            for (int ch = 0; ch < CH; ch++)
               w[((3*tr+tc)*CH+ch)*DW +: DW] = pix(ch, row - 2 + tr, col - 2 + tc);
      return w;
   endfunction

   task automatic fill_image(input bit directed);
      for (int ch = 0; ch < CH; ch++)
         for (int r = 0; r < MAXD; r++)
            for (int c = 0; c < MAXD; c++)
               img[ch][r][c] = directed ? DW'(16*r + c + 128*ch) : DW'($urandom);
   endtask

   // One clock edge; the outputs are compared 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
      check("valid_out", WINW'(valid_out), WINW'(exp_vld));
      check("eof", WINW'(eof), WINW'(exp_eof));
      check("busy", WINW'(busy), WINW'(exp_busy));
      check("win_out", win_out, exp_win);
      if (valid_out === 1'b1) begin
         if (n_win == 0) first_win = win_out;
         n_win++;
      end
   endtask

   // gap_mode: 0 = contiguous, 1 = idle cycle before every column, 2 = random.
   // stop_at >= 0 abandons the frame once that many columns have been driven.
   task automatic run_frame(input int w, input int h, input bit s2, input bit directed,
                            input int gap_mode, input int stop_at);
      int idx;
      int row;
      int col;
      bit carry;
      bit win;
      fill_image(directed);
      n_win       = 0;
      carry       = directed ? 1'b1 : 1'($urandom_range(0, 1));
      frame_start = 1'b1;
      img_width   = DIMW'(w);
      img_height  = DIMW'(h);
      stride2     = s2;
      valid_in    = carry;
      col_in      = carry ? make_col(0, 0) : COLW'($urandom);
      exp_vld     = 1'b0;
      exp_eof     = 1'b0;
      exp_busy    = 1'b1;
      tick();
      frame_start = 1'b0;
      idx = carry ? 1 : 0;
      while (idx < w*h && idx != stop_at) begin
         if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 3) == 0)) begin
            valid_in = 1'b0;
            col_in   = COLW'($urandom);
            exp_vld  = 1'b0;
            exp_eof  = 1'b0;
            // Occasionally a degenerate frame_start, which must be ignored.
            if (gap_mode == 2 && $urandom_range(0, 7) == 0) begin
               frame_start = 1'b1;
               img_width   = DIMW'($urandom_range(0, 2));
            end
            tick();
            frame_start = 1'b0;
            img_width   = DIMW'(w);
         end
         row      = idx / w;
         col      = idx % w;
         valid_in = 1'b1;
         col_in   = make_col(row, col);
         win      = (row >= 2) && (col >= 2) && (!s2 || (row % 2 == 0 && col % 2 == 0));
         exp_vld  = win;
         if (win) exp_win = make_win(row, col);
         exp_eof  = (idx == w*h - 1);
         tick();
         idx++;
      end
      valid_in = 1'b0;
      if (idx < w*h) return;
      // The FLUSH cycle ignores valid_in; then the block is idle again.
      valid_in = 1'b1;
      col_in   = COLW'($urandom);
      exp_vld  = 1'b0;
      exp_eof  = 1'b0;
      exp_busy = 1'b0;
      tick();
      valid_in = 1'b0;
      check("win_count", WINW'(n_win),
            WINW'(s2 ? ((w-1)/2) * ((h-1)/2) : (w-2) * (h-2)));
   endtask

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      n_win       = 0;
      rstn        = 1'b0;
      col_in      = '0;
      valid_in    = 1'b0;
      frame_start = 1'b0;
      img_width   = '0;
      img_height  = '0;
      stride2     = 1'b0;
      exp_vld     = 1'b0;
      exp_eof     = 1'b0;
      exp_busy    = 1'b0;
      exp_win     = '0;
      first_win   = '0;

      // Reset state.
      tick();
      tick();
      rstn = 1'b1;

      // Columns before any frame_start are ignored.
      repeat (4) begin
         valid_in = 1'b1;
         col_in   = COLW'($urandom);
         tick();
      end

      // Degenerate frame sizes are ignored and busy stays low.
      frame_start = 1'b1;
      img_width   = DIMW'(2);
      img_height  = DIMW'(5);
      tick();
      img_width   = DIMW'(8);
      img_height  = DIMW'(1);
      tick();
      frame_start = 1'b0;
      valid_in    = 1'b0;
      tick();

      // Stride 1, 4x4, contiguous; explicit first-window taps.
      run_frame(4, 4, 1'b0, 1'b1, 0, -1);
      for (int k = 0; k < 9; k++)
         check("tap", WINW'(first_win[k*CH*DW +: DW]), WINW'(TAP_REF[(8-k)*8 +: 8]));

      // Same frame with valid_in toggling every other cycle.
      run_frame(4, 4, 1'b0, 1'b1, 1, -1);
      for (int k = 0; k < 9; k++)
         check("tap_gap", WINW'(first_win[k*CH*DW +: DW]), WINW'(TAP_REF[(8-k)*8 +: 8]));

      // Stride 2, 5x5; then 6x4, where eof arrives without a window.
      run_frame(5, 5, 1'b1, 1'b1, 0, -1);
      run_frame(6, 4, 1'b1, 1'b1, 0, -1);

      // New frame_start arriving at row 2, col 1 of a frame in progress.
      run_frame(6, 5, 1'b0, 1'b0, 0, 2*6 + 1);
      run_frame(3, 3, 1'b0, 1'b0, 0, -1);

      // Reset in the middle of row 3.
      run_frame(5, 5, 1'b0, 1'b0, 2, 3*5 + 1);
      #2;
      rstn = 1'b0;
      #1;
      check("rst_valid", WINW'(valid_out), WINW'(0));
      check("rst_eof", WINW'(eof), WINW'(0));
      check("rst_busy", WINW'(busy), WINW'(0));
      check("rst_win", win_out, '0);
      exp_vld  = 1'b0;
      exp_eof  = 1'b0;
      exp_busy = 1'b0;
      exp_win  = '0;
      #1;
      rstn = 1'b1;
      repeat (6) begin
         valid_in = 1'($urandom_range(0, 1));
         col_in   = COLW'($urandom);
         tick();
      end
      valid_in = 1'b0;

      // Random frames with random gaps.
      repeat (10)
         run_frame(int'($urandom_range(3, 12)), int'($urandom_range(3, 10)),
                   1'($urandom_range(0, 1)), 1'b0, 2, -1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
